aes_inv_round_engine: RTL and testbench
=======================================

Name: aes_inv_round_engine

Overview:
Iterative AES inverse cipher: decrypts one 128-bit block at a rate of one round per clock. Sits on the decrypt path, opposite the encrypt-side round logic (SubBytes/ShiftRows/MixColumns).
- Round keys come from an external key store, indexed by RkIdx.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- ROUNDS, 10, number of cipher rounds; legal values 10/12/14 (AES-128/192/256). The key store must supply keys 0..ROUNDS.

Ports:
- Clk  in  1  clock; all state on rising edge
- Rst  in  1  asynchronous, active-high reset
- InValid  in  1  ciphertext valid
- InReady  out  1  engine can accept a block
- CipherIn  in  128  ciphertext; byte 0 at [127:120], column-major (bytes 0-3 = column 0)
- RkIdx  out  4  round-key index requested this cycle
- RoundKey  in  128  round key for RkIdx; combinational, same cycle, same byte order
- OutValid  out  1  plaintext valid
- OutReady  in  1  downstream accepts plaintext
- PlainOut  out  128  plaintext

Behaviour:
- Reset is asynchronous, active-high, on Rst. Reset values: FSM=IDLE, state reg=0, round counter=ROUNDS, OutValid=0, PlainOut=0, RkIdx=ROUNDS. InReady=1 once Rst deasserts.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - InReady=1, RkIdx=ROUNDS.
  - On InValid&&InReady: State <= CipherIn ^ RoundKey; Rnd <= ROUNDS-1; go to ROUND.
- ROUND:
  - RkIdx=Rnd.
  - State <= InvMixColumns(InvSubBytes(InvShiftRows(State)) ^ RoundKey).
  - Rnd decrements; when Rnd==1, go to FINAL.
- FINAL:
  - RkIdx=0.
  - State <= InvSubBytes(InvShiftRows(State)) ^ RoundKey.
  - Go to DONE.
- DONE:
  - OutValid=1, PlainOut=State.
  - On OutReady go to IDLE. OutValid drops the next cycle.
- InvShiftRows: row r is rotated right by r. Output byte (row r, col c) = input byte (row r, col (c-r) mod 4). Row 0 is unchanged.
- InvMixColumns: per column, multiply by matrix {0e,0b,0d,09} (circulant) over GF(2^8), reduction polynomial 0x11B.
- Latency: accept at cycle t → OutValid at t+ROUNDS+1 (t+11 for AES-128).
- Throughput: one block per ROUNDS+2 cycles, with no overlap.
- InReady is 0 in ROUND, FINAL and DONE. CipherIn is sampled only on the accept cycle and may change afterwards.
- Backpressure: with OutReady low in DONE, PlainOut and OutValid hold stable indefinitely.
- OutReady high while not in DONE is ignored.
- Rst asserted mid-operation aborts the block. No OutValid is produced for it; the engine returns to IDLE.
- RkIdx is a function of state only (Moore), never of inputs.

Optional Feature:
- Macro: AES_INV_CLEAR_EN (state-scrubbing).
- Defined:
  - The state register is zeroed on the DONE→IDLE transition.
  - PlainOut is forced to 0 whenever OutValid=0.
- Undefined:
  - The state register retains the last plaintext after handoff.
  - PlainOut reflects the state register in all states.

Decomposition:
- Package aes_pkg:
  - typedef for 128-bit state and 8-bit byte
  - localparam for the GF reduction constant 8'h1B
  - functions xtime, gf_mul, inv_shift_rows, inv_mix_columns
- Sub-module aes_inv_sbox: 8-bit in → 8-bit out, combinational inverse S-box table. Instantiated 16x for InvSubBytes.
- The bench supplies round keys from a reference key-expansion model.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, CipherIn 69c4e0d86a7b0430d8cdb78070b4c55a → PlainOut 00112233445566778899aabbccddeeff, OutValid exactly 11 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, CipherIn 3925841d02dc09fbdc118597196a0b32 → PlainOut 3243f6a8885a308d313198a2e0370734. RkIdx sequence 10,9,…,1,0 across the accept..FINAL cycles.
- Backpressure: hold OutReady=0 for 5 cycles in DONE → PlainOut and OutValid stable, InReady=0, and a new InValid is not accepted.
- Back-to-back: InValid held high with two blocks and OutReady=1 → second accept occurs 12 cycles after the first; both plaintexts are correct.
- Reset mid-round: assert Rst at round 5 → OutValid=0 and PlainOut=0 immediately, InReady=1 after release, and the next block decrypts correctly.
- With AES_INV_CLEAR_EN defined: after handoff PlainOut=0; a while idle PlainOut=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the inverse round engine.
// Byte i of a 128-bit state sits at [127-8i -: 8]; row = i % 4, column = i / 4.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

  localparam byte_t GfRed = 8'h1B;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GfRed : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r rotates right by r: out(r, c) = in(r, (c - r) mod 4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^
                         gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^
                         gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^
                         gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^
                         gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module aes_inv_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e,
    8'h81, 8'hf3, 8'hd7, 8'hfb, 8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb, 8'h54, 8'h7b, 8'h94, 8'h32,
    8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49,
    8'h6d, 8'h8b, 8'hd1, 8'h25, 8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92, 8'h6c, 8'h70, 8'h48, 8'h50,
    8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05,
    8'hb8, 8'hb3, 8'h45, 8'h06, 8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b, 8'h3a, 8'h91, 8'h11, 8'h41,
    8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8,
    8'h1c, 8'h75, 8'hdf, 8'h6e, 8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b, 8'hfc, 8'h56, 8'h3e, 8'h4b,
    8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59,
    8'h27, 8'h80, 8'hec, 8'h5f, 8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef, 8'ha0, 8'he0, 8'h3b, 8'h4d,
    8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63,
    8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign data_o = InvSbox[data_i];

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched via RkIdx.
// Optional macro AES_INV_CLEAR_EN scrubs the state on handoff and masks PlainOut when idle.
module aes_inv_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] CipherIn,
  output logic [3:0]   RkIdx,
  input  logic [127:0] RoundKey,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] PlainOut
);

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;

  state_t isr, sub, add_key;

  assign isr = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .data_i(isr[127-8*i -: 8]),
      .data_o(sub[127-8*i -: 8])
    );
  end

  assign add_key = sub ^ RoundKey;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      StIdle: begin
        if (InValid) begin
          state_d = CipherIn ^ RoundKey;
          rnd_d   = 4'(ROUNDS - 1);
          fsm_d   = StRound;
        end
      end
      StRound: begin
        state_d = inv_mix_columns(add_key);
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = StFinal;
      end
      StFinal: begin
        state_d = add_key;
        fsm_d   = StDone;
      end
      StDone: begin
        if (OutReady) begin
          fsm_d = StIdle;
`ifdef AES_INV_CLEAR_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    RkIdx = 4'(ROUNDS);
    unique case (fsm_q)
      StRound: RkIdx = rnd_q;
      StFinal: RkIdx = 4'd0;
      default: RkIdx = 4'(ROUNDS);
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      rnd_q   <= 4'(ROUNDS);
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign InReady  = (fsm_q == StIdle);
  assign OutValid = (fsm_q == StDone);

`ifdef AES_INV_CLEAR_EN
  assign PlainOut = OutValid ? state_q : '0;
`else
  assign PlainOut = state_q;
`endif

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Self-checking bench: FIPS vectors plus random blocks encrypted by a forward-cipher model.
module tb_aes_inv_round_engine;

  localparam int ROUNDS = 10;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [127:0] CipherIn = '0;
  logic [3:0]   RkIdx;
  logic [127:0] RoundKey;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic [127:0] PlainOut;

  int checks = 0;
  int errors = 0;

  logic [7:0]   fwd_sbox [256];
  logic [127:0] rk [16];

  aes_inv_round_engine #(.ROUNDS(ROUNDS)) u_dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .CipherIn(CipherIn),
    .RkIdx(RkIdx), .RoundKey(RoundKey), .OutValid(OutValid), .OutReady(OutReady),
    .PlainOut(PlainOut)
  );

  always #5 Clk = ~Clk;

  assign RoundKey = (int'(RkIdx) <= ROUNDS) ? rk[RkIdx] : '0;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      fwd_sbox[x] = s;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {fwd_sbox[t[23:16]], fwd_sbox[t[15:8]], fwd_sbox[t[7:0]], fwd_sbox[t[31:24]]} ^
            {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= ROUNDS; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= ROUNDS; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = fwd_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != ROUNDS) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Accept one block, check RkIdx schedule, latency, result, optional backpressure and handoff.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           input int hold);
    int n;
    n = 0;
    while (!InReady && n < 50) begin tick; n++; end
    check({tag, " ready"}, 128'(InReady), 128'(1));
    InValid  = 1'b1;
    CipherIn = ct;
    check({tag, " rkidx accept"}, 128'(RkIdx), 128'(ROUNDS));
    tick;
    InValid  = 1'b0;
    CipherIn = {$urandom, $urandom, $urandom, $urandom};
    check({tag, " busy"}, 128'(InReady), 128'(0));
    n = 1;
    while (!OutValid && n < 50) begin
      if (n <= ROUNDS) check({tag, " rkidx"}, 128'(RkIdx), 128'(ROUNDS - n));
      tick;
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(ROUNDS + 1));
    check({tag, " plain"}, PlainOut, exp);
    for (int h = 0; h < hold; h++) begin
      InValid  = 1'b1;
      CipherIn = {$urandom, $urandom, $urandom, $urandom};
      tick;
      check({tag, " hold valid"}, 128'(OutValid), 128'(1));
      check({tag, " hold plain"}, PlainOut, exp);
      check({tag, " hold ready"}, 128'(InReady), 128'(0));
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    tick;
    OutReady = 1'b0;
    check({tag, " valid drop"}, 128'(OutValid), 128'(0));
    check({tag, " idle ready"}, 128'(InReady), 128'(1));
`ifdef AES_INV_CLEAR_EN
    check({tag, " scrubbed"}, PlainOut, '0);
`else
    check({tag, " retained"}, PlainOut, exp);
`endif
  endtask

  initial begin
    logic [127:0] key, pt, ct;
    logic [127:0] b2b_ct [2];
    logic [127:0] b2b_pt [2];
    int acc_cyc [2];
    int k, got, n;
    logic acc_now;

    build_sbox();
    for (int r = 0; r < 16; r++) rk[r] = '0;

    // Reset state
    tick; tick;
    check("reset valid", 128'(OutValid), 128'(0));
    check("reset plain", PlainOut, '0);
    check("reset rkidx", 128'(RkIdx), 128'(ROUNDS));
    Rst = 1'b0;
    tick;
    check("reset ready", 128'(InReady), 128'(1));

    // FIPS-197 C.1
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    run_block("c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 0);
    tick; tick; tick;
`ifdef AES_INV_CLEAR_EN
    check("idle scrubbed", PlainOut, '0);
`else
    check("idle retained", PlainOut, 128'h00112233445566778899aabbccddeeff);
`endif

    // FIPS-197 App. B, with 5 cycles of backpressure in DONE
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block("appb", 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 5);

    // Random keys/plaintexts through the forward model
    for (int i = 0; i < 3; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      ct = encrypt(pt);
      run_block("rand", ct, pt, i);
    end

    // Back-to-back with InValid held high and OutReady high
    for (int i = 0; i < 2; i++) begin
      b2b_pt[i] = {$urandom, $urandom, $urandom, $urandom};
      b2b_ct[i] = encrypt(b2b_pt[i]);
    end
    InValid  = 1'b1;
    CipherIn = b2b_ct[0];
    OutReady = 1'b1;
    k   = 0;
    got = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    for (int c = 0; c < 60 && got < 2; c++) begin
      if (OutValid) begin
        check("b2b plain", PlainOut, b2b_pt[got]);
        got++;
      end
      acc_now = InReady && InValid;
      tick;
      if (acc_now) begin
        acc_cyc[k] = c;
        k++;
        if (k == 2) InValid = 1'b0;
        else CipherIn = b2b_ct[1];
      end
    end
    InValid  = 1'b0;
    OutReady = 1'b0;
    check("b2b outputs", 128'(got), 128'(2));
    check("b2b accepts", 128'(k), 128'(2));
    check("b2b spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(ROUNDS + 2));
    tick;

    // Reset in the middle of round 5
    pt = {$urandom, $urandom, $urandom, $urandom};
    ct = encrypt(pt);
    InValid  = 1'b1;
    CipherIn = ct;
    tick;
    InValid = 1'b0;
    n = 0;
    while (RkIdx != 4'd5 && n < 30) begin tick; n++; end
    check("mid rkidx", 128'(RkIdx), 128'(5));
    Rst = 1'b1;
    #1;
    check("mid rst valid", 128'(OutValid), 128'(0));
    check("mid rst plain", PlainOut, '0);
    tick;
    Rst = 1'b0;
    tick;
    check("mid rst ready", 128'(InReady), 128'(1));
    check("mid rst no out", 128'(OutValid), 128'(0));
    run_block("post rst", ct, pt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
